// File: rtl/collision_handler.sv
// Per-frame collision evaluator: lives, invulnerability window and game-over.
// Define COLLISION_EXPLOSION_DAMAGE_EN to make explosions cost a life.
module collision_handler #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       game_start,
  input  logic       collission_bomber_wall,
  input  logic       collission_bomber_mine,
  input  logic       collission_bomber_explosion,
  output logic       wall_hit,
  output logic       damage_pulse,
  output logic [2:0] bomber_lives,
  output logic       invulnerable,
  output logic       game_over
);

  localparam logic [2:0] LIV = 3'(LIVES);
  localparam logic [7:0] INV = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_HURT,
    S_OVER
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wall_hit_q, wall_hit_d;
  logic       dmg_pulse_q, dmg_pulse_d;
  logic       inv_q, over_q;
  logic       wall_f_q, wall_f_d;
  logic       mine_f_q, mine_f_d;
  logic       clr;
  logic       dmg;

  // A clear (frame boundary or new game) beats a same-cycle collision
  assign wall_f_d = (startOfFrame | clr) ? 1'b0
                  : (wall_f_q | collission_bomber_wall);
  assign mine_f_d = (startOfFrame | clr) ? 1'b0
                  : (mine_f_q | collission_bomber_mine);

`ifdef COLLISION_EXPLOSION_DAMAGE_EN
  logic expl_f_q, expl_f_d;

  assign expl_f_d = (startOfFrame | clr) ? 1'b0
                  : (expl_f_q | collission_bomber_explosion);
  assign dmg = mine_f_q | expl_f_q;

  always_ff @(posedge clk) begin
    if (reset) expl_f_q <= 1'b0;
    else       expl_f_q <= expl_f_d;
  end
`else
  logic unused_expl;

  assign unused_expl = collission_bomber_explosion;
  assign dmg         = mine_f_q;
`endif

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    cnt_d       = cnt_q;
    wall_hit_d  = 1'b0;
    dmg_pulse_d = 1'b0;
    clr         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        lives_d = LIV;
        if (game_start) begin
          state_d = S_PLAY;
          clr     = 1'b1;
        end
      end
      S_PLAY: begin
        if (startOfFrame) begin
          wall_hit_d = wall_f_q;
          if (dmg && lives_q != 3'd0) begin
            dmg_pulse_d = 1'b1;
            lives_d     = lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_d = S_OVER;
            end else begin
              cnt_d   = INV;
              state_d = S_HURT;
            end
          end
        end
      end
      S_HURT: begin
        if (startOfFrame) begin
          wall_hit_d = wall_f_q;
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_d = S_PLAY;
        end
      end
      S_OVER: begin
        lives_d = 3'd0;
        if (game_start) begin
          state_d = S_PLAY;
          lives_d = LIV;
          clr     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lives_q     <= LIV;
      cnt_q       <= 8'd0;
      wall_hit_q  <= 1'b0;
      dmg_pulse_q <= 1'b0;
      inv_q       <= 1'b0;
      over_q      <= 1'b0;
      wall_f_q    <= 1'b0;
      mine_f_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      wall_hit_q  <= wall_hit_d;
      dmg_pulse_q <= dmg_pulse_d;
      inv_q       <= (state_d == S_HURT);
      over_q      <= (state_d == S_OVER);
      wall_f_q    <= wall_f_d;
      mine_f_q    <= mine_f_d;
    end
  end

  assign wall_hit     = wall_hit_q;
  assign damage_pulse = dmg_pulse_q;
  assign bomber_lives = lives_q;
  assign invulnerable = inv_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_collision_handler.sv
// Directed + random bench for collision_handler against a frame-level model.
// LIVES=3, INVULN_FRAMES=2 keep invulnerability and game-over short.
module tb_collision_handler;

  localparam int LIVES = 3;
  localparam int INVF  = 2;

  logic       clk = 1'b0;
  logic       reset, startOfFrame, game_start;
  logic       cw, cm, ce;
  logic       wall_hit, damage_pulse, invulnerable, game_over;
  logic [2:0] bomber_lives;

  int errors = 0;
  int checks = 0;

  // model: mode 0 idle, 1 playing, 2 game over; inv_left>0 means hurt
  int mode, inv_left, lives;
  bit seen_w, seen_m, seen_e;
  bit e_wall, e_dmg;
  bit expl_dmg;

  collision_handler #(.LIVES(LIVES), .INVULN_FRAMES(INVF)) dut (
    .clk                         (clk),
    .reset                       (reset),
    .startOfFrame                (startOfFrame),
    .game_start                  (game_start),
    .collission_bomber_wall      (cw),
    .collission_bomber_mine      (cm),
    .collission_bomber_explosion (ce),
    .wall_hit                    (wall_hit),
    .damage_pulse                (damage_pulse),
    .bomber_lives                (bomber_lives),
    .invulnerable                (invulnerable),
    .game_over                   (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit enter;
    e_wall = 0;
    e_dmg  = 0;
    if (reset) begin
      mode = 0; inv_left = 0; lives = LIVES;
      seen_w = 0; seen_m = 0; seen_e = 0;
      return;
    end
    enter = (mode != 1) && game_start;
    if (enter) begin
      mode = 1; inv_left = 0; lives = LIVES;
    end else if (mode == 1 && startOfFrame) begin
      e_wall = seen_w;
      if (inv_left > 0) begin
        inv_left--;
      end else if (seen_m || (expl_dmg && seen_e)) begin
        e_dmg = 1;
        lives--;
        if (lives == 0) mode = 2;
        else inv_left = INVF;
      end
    end
    if (startOfFrame || enter) begin
      seen_w = 0; seen_m = 0; seen_e = 0;
    end else begin
      seen_w |= cw; seen_m |= cm; seen_e |= ce;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit g,
                      input bit w, input bit m, input bit e);
    reset = r; startOfFrame = s; game_start = g;
    cw = w; cm = m; ce = e;
    @(posedge clk);
    model_edge();
    #1;
    chk("wall_hit", int'(wall_hit), int'(e_wall));
    chk("damage_pulse", int'(damage_pulse), int'(e_dmg));
    chk("bomber_lives", int'(bomber_lives), (mode == 2) ? 0 : lives);
    chk("invulnerable", int'(invulnerable), int'(mode == 1 && inv_left > 0));
    chk("game_over", int'(game_over), int'(mode == 2));
  endtask

  // n collision cycles, then a clean frame boundary and one quiet cycle
  task automatic frame(input int n, input bit w, input bit m, input bit e);
    for (int i = 0; i < n; i++) step(0, 0, 0, w, m, e);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
`ifdef COLLISION_EXPLOSION_DAMAGE_EN
    expl_dmg = 1;
`else
    expl_dmg = 0;
`endif
    mode = 0; inv_left = 0; lives = LIVES;
    seen_w = 0; seen_m = 0; seen_e = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // start, mine for 5 cycles mid-frame
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    frame(5, 0, 1, 0);
    // hurt: two protected frames, then a hit counts again
    frame(3, 0, 1, 0);
    frame(3, 0, 1, 0);
    frame(3, 0, 1, 0);
    // wall only in hurt, then in play
    frame(2, 1, 0, 0);
    frame(2, 1, 0, 0);
    frame(2, 1, 0, 0);
    // collision only on the boundary cycle
    step(0, 1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    frame(1, 0, 0, 0);
    // last life
    frame(2, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // explosion in play
    frame(3, 0, 0, 1);
    // reset while hurt
    frame(3, 0, 1, 0);
    frame(3, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    // start coinciding with a frame boundary in idle
    step(0, 1, 1, 1, 1, 1);
    frame(2, 0, 0, 0);
    // randomized frames
    for (int f = 0; f < 150; f++) begin
      int len;
      len = int'($urandom_range(2, 9));
      for (int c = 0; c < len; c++)
        step($urandom_range(0, 99) == 0, 0,
             $urandom_range(0, 11) == 0,
             $urandom_range(0, 6) == 0,
             $urandom_range(0, 8) == 0,
             $urandom_range(0, 8) == 0);
      step(0, 1, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
